data_mem_ctl: RTL and testbench
===============================

// Module: data_mem_ctl
// PURPOSE
//  Parametrised single-port data RAM for the processor datapath; successor to the 8x256 data memory.
//  Adds configurable width/depth, a registered (1-cycle) read with valid strobe, and selectable read-during-write.
//  Adds a post-reset clear sweep with Ready handshake and out-of-range address detection.
//  Sits between the ALU/address path and the register-file writeback mux.
// PARAMETERS
//  DW        8    data width in bits
//  AW        8    address width in bits
//  DEPTH     256  number of words; 1 <= DEPTH <= 2**AW
//  RDW_MODE  0    same-address read+write in one cycle: 0 = return old data, 1 = return new (write-through)
//  CLEAR_EN  1    1 = zero all DEPTH words after reset before Ready; 0 = skip sweep
// PORTS
//  CLK          in   1    clock, all state updates on rising edge
//  Reset_n      in   1    synchronous active-low reset
//  DataAddress  in   AW   word address for read and/or write
//  ReadMem      in   1    read request, sampled at posedge
//  WriteMem     in   1    write request, sampled at posedge
//  DataIn       in   DW   write data
//  DataOut      out  DW   registered read data; holds last value between reads
//  RdValid      out  1    one-cycle pulse: DataOut updated by the read accepted on the previous edge
//  Ready        out  1    1 = requests accepted; 0 = clearing or in reset
//  AddrErr      out  1    one-cycle pulse: accepted request had DataAddress >= DEPTH
// BEHAVIOUR
//  Reset (Reset_n=0 at posedge): state<=CLEAR (CLEAR_EN=1) or RUN (CLEAR_EN=0); ClrCnt<=0;
//   DataOut<=0, RdValid<=0, Ready<=0, AddrErr<=0. Memory contents are untouched by reset itself.
//  FSM states: CLEAR, RUN.
//   CLEAR: each cycle writes 0 to mem[ClrCnt], ClrCnt++. On the edge writing ClrCnt==DEPTH-1 -> RUN.
//          Ready is 0 throughout. Ready=1 on the first cycle after the sweep (DEPTH edges after reset release).
//   RUN:   Ready=1. Stays here until reset.
//   CLEAR_EN=0: RUN entered on the first edge after reset release; Ready=1 one cycle after release.
//  Requests are ignored entirely while Ready=0: no write, no RdValid, no AddrErr.
//  Write (RUN, WriteMem=1, addr<DEPTH): mem[addr]<=DataIn at the edge.
//  Read  (RUN, ReadMem=1, addr<DEPTH): DataOut<=mem[addr] at the edge; RdValid=1 for the following cycle.
//   Latency: request at edge N -> data/RdValid visible after edge N, i.e. one cycle.
//  Read+write same cycle: both performed. Same address: DataOut=DataIn if RDW_MODE=1, else prior contents.
//   Different addresses: independent.
//  Out of range (addr>=DEPTH) with ReadMem|WriteMem in RUN: write dropped; a read sets DataOut<=0 and pulses RdValid;
//   AddrErr=1 for the next cycle. Not reachable when DEPTH==2**AW.
//  No request: DataOut holds, RdValid=0, AddrErr=0. The output is never high-Z.
//  Reset mid-CLEAR or mid-RUN: the sweep restarts from address 0. Back-to-back requests are allowed every cycle.
//  ClrCnt is wide enough to hold DEPTH-1 and never wraps; the sweep terminates on the compare.
// TESTING
//  T1 reset, CLEAR_EN=1, DEPTH=256: Reset_n low 2 cyc, release -> Ready=0 for 256 cyc then 1; read 0..255 all return 0.
//  T2 write M[5]=8'hA7, next cyc read 5 -> DataOut=8'hA7 with RdValid=1 exactly one cycle after the read edge.
//  T3 M[9]=8'h11, then same cycle WriteMem+ReadMem addr 9 DataIn=8'h22 -> RDW_MODE=0: DataOut=8'h11; RDW_MODE=1: 8'h22; M[9]=8'h22 after.
//  T4 DEPTH=200: write addr 210 DataIn=8'hFF -> AddrErr pulse, no store; read 210 -> DataOut=0, RdValid=1, AddrErr=1.
//  T5 assert Reset_n=0 at ClrCnt=100 -> sweep restarts at 0; Ready rises 256 cyc after release; writes attempted while Ready=0 not stored.
//  T6 DW=16, AW=4, DEPTH=16, CLEAR_EN=0: Ready 1 cyc after reset; reads 0..15 of 16'h1234+i every cycle, back-to-back -> RdValid continuous, data in order.

Source files
------------

// File: rtl/data_mem_ctl.sv
`default_nettype none
// ============================================================================
// data_mem_ctl : single-port data RAM, registered read, post-reset clear sweep
// Revision     : 1.0
// ============================================================================
module data_mem_ctl #(
  parameter int DW       = 8,
  parameter int AW       = 8,
  parameter int DEPTH    = 256,
  parameter int RDW_MODE = 0,
  parameter int CLEAR_EN = 1
) (
  input  logic          CLK,
  input  logic          Reset_n,
  input  logic [AW-1:0] DataAddress,
  input  logic          ReadMem,
  input  logic          WriteMem,
  input  logic [DW-1:0] DataIn,
  output logic [DW-1:0] DataOut,
  output logic          RdValid,
  output logic          Ready,
  output logic          AddrErr
);

  localparam int CW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW1 = AW + 1;
  localparam logic [CW-1:0] C_CLR_LAST = CW'(DEPTH - 1);
  localparam logic [AW:0]   C_DEPTH    = AW1'(DEPTH);

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;
  localparam state_t C_RESET_STATE = (CLEAR_EN != 0) ? S_CLEAR : S_RUN;

  logic [DW-1:0] mem [DEPTH];

  state_t        state_q, state_d;
  logic [CW-1:0] clr_cnt_q, clr_cnt_d;
  logic          ready_q;
  logic [DW-1:0] dout_q;
  logic          rd_valid_q;
  logic          addr_err_q;

  logic          w_in_range;
  logic          w_rd_req;
  logic          w_wr_req;
  logic          w_wr_en;
  logic [CW-1:0] w_idx;
  logic [DW-1:0] w_rd_data;

  assign w_in_range = ({1'b0, DataAddress} < C_DEPTH);
  assign w_rd_req   = ready_q & ReadMem;
  assign w_wr_req   = ready_q & WriteMem;
  assign w_wr_en    = w_wr_req & w_in_range;
  assign w_idx      = DataAddress[CW-1:0];

  // Write-through bypass only matters when a write hits the same (single) address.
  always_comb begin
    w_rd_data = '0;
    if (w_in_range) begin
      if ((RDW_MODE != 0) && w_wr_req) w_rd_data = DataIn;
      else                             w_rd_data = mem[w_idx];
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      S_CLEAR: begin
        if (clr_cnt_q == C_CLR_LAST) state_d = S_RUN;
        else                         clr_cnt_d = clr_cnt_q + CW'(1);
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = C_RESET_STATE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state_q    <= C_RESET_STATE;
      clr_cnt_q  <= '0;
      ready_q    <= 1'b0;
      dout_q     <= '0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      ready_q    <= (state_d == S_RUN);
      rd_valid_q <= w_rd_req;
      addr_err_q <= (w_rd_req | w_wr_req) & ~w_in_range;
      if (w_rd_req) dout_q <= w_rd_data;
    end
  end

  // Storage is deliberately left out of reset; only the sweep zeroes it.
  always_ff @(posedge CLK) begin
    if (Reset_n) begin
      if (state_q == S_CLEAR) mem[clr_cnt_q] <= '0;
      else if (w_wr_en)       mem[w_idx]     <= DataIn;
    end
  end

  assign DataOut = dout_q;
  assign RdValid = rd_valid_q;
  assign Ready   = ready_q;
  assign AddrErr = addr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctl.sv
`default_nettype none
// ============================================================================
// tb_data_mem_ctl : directed vector bench over three data_mem_ctl configurations
// Revision        : 1.0
// ============================================================================
module tb_data_mem_ctl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] addr, din;
  logic       rd, wr;
  logic [7:0] dout0, dout1;
  logic       rv0, rdy0, ae0, rv1, rdy1, ae1;

  logic [3:0]  addr2;
  logic [15:0] din2, dout2;
  logic        rd2, wr2, rv2, rdy2, ae2;

  int checks   = 0;
  int failures = 0;

  data_mem_ctl #(.DW(8), .AW(8), .DEPTH(256), .RDW_MODE(0), .CLEAR_EN(1)) u_dut0 (
    .CLK(clk), .Reset_n(rst_n), .DataAddress(addr), .ReadMem(rd), .WriteMem(wr),
    .DataIn(din), .DataOut(dout0), .RdValid(rv0), .Ready(rdy0), .AddrErr(ae0));

  data_mem_ctl #(.DW(8), .AW(8), .DEPTH(200), .RDW_MODE(1), .CLEAR_EN(1)) u_dut1 (
    .CLK(clk), .Reset_n(rst_n), .DataAddress(addr), .ReadMem(rd), .WriteMem(wr),
    .DataIn(din), .DataOut(dout1), .RdValid(rv1), .Ready(rdy1), .AddrErr(ae1));

  data_mem_ctl #(.DW(16), .AW(4), .DEPTH(16), .RDW_MODE(0), .CLEAR_EN(0)) u_dut2 (
    .CLK(clk), .Reset_n(rst_n), .DataAddress(addr2), .ReadMem(rd2), .WriteMem(wr2),
    .DataIn(din2), .DataOut(dout2), .RdValid(rv2), .Ready(rdy2), .AddrErr(ae2));

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] addr;
    logic [7:0] din;
    logic [7:0] d0;
    logic       v0;
    logic       e0;
    logic [7:0] d1;
    logic       v1;
    logic       e1;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Releases reset and returns the first cycle index at which each Ready is seen high.
  task automatic count_ready(input int wr_lo, input int wr_hi,
                             output int c0, output int c1, output int c2);
    c0 = 0; c1 = 0; c2 = 0;
    rst_n = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      wr   = (i > wr_lo) && (i <= wr_hi);
      addr = 8'd3;
      din  = 8'hEE;
      step();
      if (rdy0 && c0 == 0) c0 = i;
      if (rdy1 && c1 == 0) c1 = i;
      if (rdy2 && c2 == 0) c2 = i;
    end
    wr = 1'b0;
  endtask

  task automatic read_both(input logic [7:0] a, input logic [7:0] e0, input logic [7:0] e1);
    addr = a; rd = 1'b1; wr = 1'b0;
    step();
    check($sformatf("rd%0d dout0", a), 32'(dout0), 32'(e0));
    check($sformatf("rd%0d dout1", a), 32'(dout1), 32'(e1));
    check($sformatf("rd%0d rv0", a), 32'(rv0), 32'd1);
    rd = 1'b0;
  endtask

  initial begin
    int c0, c1, c2;

    rst_n = 1'b0; addr = '0; din = '0; rd = 1'b0; wr = 1'b0;
    addr2 = '0; din2 = '0; rd2 = 1'b0; wr2 = 1'b0;

    vecs[0]  = '{1'b1, 1'b0, 8'd5,   8'hA7, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 8'd5,   8'h00, 8'hA7, 1'b1, 1'b0, 8'hA7, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 8'd9,   8'h11, 8'hA7, 1'b0, 1'b0, 8'hA7, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 8'd9,   8'h22, 8'h11, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 8'd9,   8'h00, 8'h22, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 8'd210, 8'hFF, 8'h22, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 8'd210, 8'h00, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 8'd0,   8'h00, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 8'd210, 8'h33, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 8'd210, 8'h00, 8'h33, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 8'd199, 8'h5A, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 8'd199, 8'h00, 8'h5A, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 8'd200, 8'h77, 8'h5A, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 8'd200, 8'h00, 8'h77, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 8'd5,   8'h00, 8'hA7, 1'b1, 1'b0, 8'hA7, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 8'd9,   8'h00, 8'h22, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0};

    // Reset state
    step(); step();
    check("rst rdy0", 32'(rdy0), 32'd0);
    check("rst rdy1", 32'(rdy1), 32'd0);
    check("rst rdy2", 32'(rdy2), 32'd0);
    check("rst dout0", 32'(dout0), 32'd0);
    check("rst rv0", 32'(rv0), 32'd0);
    check("rst ae1", 32'(ae1), 32'd0);

    // Sweep length to Ready
    count_ready(0, 0, c0, c1, c2);
    check("sweep0 cycles", 32'(c0), 32'd256);
    check("sweep1 cycles", 32'(c1), 32'd200);
    check("noclear2 cycles", 32'(c2), 32'd1);

    // Read every address after the sweep; dut1 flags the tail as out of range
    for (int i = 0; i < 256; i++) begin
      addr = 8'(i); rd = 1'b1;
      step();
      check($sformatf("t1 dout0[%0d]", i), 32'(dout0), 32'd0);
      check($sformatf("t1 rv0[%0d]", i), 32'(rv0), 32'd1);
      check($sformatf("t1 dout1[%0d]", i), 32'(dout1), 32'd0);
      check($sformatf("t1 rv1[%0d]", i), 32'(rv1), 32'd1);
      check($sformatf("t1 ae1[%0d]", i), 32'(ae1), (i >= 200) ? 32'd1 : 32'd0);
    end
    rd = 1'b0;

    for (int i = 0; i < 16; i++) begin
      wr = vecs[i].wr; rd = vecs[i].rd; addr = vecs[i].addr; din = vecs[i].din;
      step();
      check($sformatf("v%0d dout0", i), 32'(dout0), 32'(vecs[i].d0));
      check($sformatf("v%0d rv0", i),   32'(rv0),   32'(vecs[i].v0));
      check($sformatf("v%0d ae0", i),   32'(ae0),   32'(vecs[i].e0));
      check($sformatf("v%0d dout1", i), 32'(dout1), 32'(vecs[i].d1));
      check($sformatf("v%0d rv1", i),   32'(rv1),   32'(vecs[i].v1));
      check($sformatf("v%0d ae1", i),   32'(ae1),   32'(vecs[i].e1));
    end
    wr = 1'b0; rd = 1'b0;

    // Dirty some words, reset mid-sweep, then try writing while not Ready
    addr = 8'd0;   din = 8'h5C; wr = 1'b1; step();
    addr = 8'd150; din = 8'hC3; step();
    addr = 8'd3;   din = 8'h3C; step();
    wr = 1'b0;
    rst_n = 1'b0; step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) step();
    check("midclear rdy0", 32'(rdy0), 32'd0);
    rst_n = 1'b0; step(); step();
    count_ready(120, 130, c0, c1, c2);
    check("restart0 cycles", 32'(c0), 32'd256);
    check("restart1 cycles", 32'(c1), 32'd200);
    check("restart2 cycles", 32'(c2), 32'd1);
    read_both(8'd0,   8'h00, 8'h00);
    read_both(8'd150, 8'h00, 8'h00);
    read_both(8'd3,   8'h00, 8'h00);

    // Wide, shallow, no-clear configuration: back-to-back writes then reads
    for (int i = 0; i < 16; i++) begin
      addr2 = 4'(i); din2 = 16'h1234 + 16'(i); wr2 = 1'b1;
      step();
    end
    wr2 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      addr2 = 4'(i); rd2 = 1'b1;
      step();
      check($sformatf("t6 dout2[%0d]", i), 32'(dout2), 32'(16'h1234 + 16'(i)));
      check($sformatf("t6 rv2[%0d]", i), 32'(rv2), 32'd1);
      check($sformatf("t6 ae2[%0d]", i), 32'(ae2), 32'd0);
    end
    rd2 = 1'b0;
    step();
    check("t6 idle rv2", 32'(rv2), 32'd0);
    check("t6 idle dout2", 32'(dout2), 32'h1243);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
